// File: rtl/mask_rng_pkg.sv
// Shared constants, state encoding and helpers for the masking RNG.
// The lane step and seed derivation live here so every lane agrees on them.
package mask_rng_pkg;

    localparam int LANE_W = 64;
    localparam int N_SHARES = 5;
    localparam logic [LANE_W-1:0] GOLDEN = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_WARMUP,
        ST_RUN,
        ST_FAIL
    } state_t;

    function automatic logic [LANE_W-1:0] rotl64(
        input logic [LANE_W-1:0] x,
        input int n
    );
        int s;
        s = n % LANE_W;
        if (s == 0) return x;
        return (x << s) | (x >> (LANE_W - s));
    endfunction

    function automatic logic [LANE_W-1:0] xs_step(input logic [LANE_W-1:0] x);
        logic [LANE_W-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // A lane must never sit at zero: xorshift would be stuck there forever.
    function automatic logic [LANE_W-1:0] lane_seed(
        input logic [LANE_W-1:0] seed,
        input int i
    );
        logic [LANE_W-1:0] v;
        v = seed ^ rotl64(GOLDEN, 7 * i);
        return (v == '0) ? GOLDEN : v;
    endfunction

    // One fresh word per share of the downstream refresh stage.
    function automatic int rand_words(input int shares);
        return shares;
    endfunction

endpackage

// File: rtl/mask_rng_n5_if.sv
// Seed/consume/output bundle between the RNG and its consumer.
// The consumer side drives seed and strobes; the RNG drives the words.
interface mask_rng_n5_if
    import mask_rng_pkg::*;
#(
    parameter int K_WIDTH = 32,
    parameter int RANDNUM = rand_words(N_SHARES)
);

    logic                       seed_vld;
    logic [LANE_W-1:0]          seed;
    logic                       ena;
    logic                       rnd_req;
    logic [K_WIDTH*RANDNUM-1:0] rnd;
    logic                       rnd_vld;
    logic                       health_fail;

    modport master (
        output seed_vld, seed, ena, rnd_req,
        input  rnd, rnd_vld, health_fail
    );

    modport slave (
        input  seed_vld, seed, ena, rnd_req,
        output rnd, rnd_vld, health_fail
    );

endinterface

// File: rtl/mask_rng_n5_lane.sv
// One xorshift64 lane with optional repeat detector on its output word.
// Build option: MASK_RNG_HEALTH_EN adds the previous-word register.
module xorshift64_lane
    import mask_rng_pkg::*;
#(
`ifdef MASK_RNG_HEALTH_EN
    parameter int K_WIDTH = 32
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LANE_W-1:0] load_val,
    input  logic              step,
    output logic [LANE_W-1:0] state,
    output logic              rep
);

    logic [LANE_W-1:0] nxt;

    assign nxt = xs_step(state);

    // Lane state: load beats step, step advances one xorshift round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= nxt;
        end
    end

`ifdef MASK_RNG_HEALTH_EN
    logic [K_WIDTH-1:0] prev;

    // Tracks the word currently presented so a step can be compared to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (load) begin
            prev <= load_val[K_WIDTH-1:0];
        end else if (step) begin
            prev <= nxt[K_WIDTH-1:0];
        end
    end

    // Flagged on the stepping edge itself, so a repeat is never presented.
    assign rep = step && !load && (nxt[K_WIDTH-1:0] == prev);
`else
    assign rep = 1'b0;
`endif

endmodule

// File: rtl/mask_rng_n5.sv
// Masking-randomness generator: RANDNUM xorshift64 lanes behind a small FSM.
// Build option: MASK_RNG_HEALTH_EN enables the sticky repeat health check.
module mask_rng_n5
    import mask_rng_pkg::*;
#(
    parameter int K_WIDTH = 32,
    parameter int RANDNUM = rand_words(N_SHARES),
    parameter int WARMUP  = 16
)(
    input  logic          clk,
    input  logic          rst,
    mask_rng_n5_if.slave  bus
);

    localparam int CW = $clog2(WARMUP + 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [CW-1:0]                 cnt_q;
    logic [CW-1:0]                 cnt_d;
    logic                          step;
    logic [RANDNUM-1:0]            rep_vec;
    logic [RANDNUM-1:0][LANE_W-1:0] lane_st;
    logic                          unused_bits;

    // Lanes advance every warm-up edge, or on an enabled consume in RUN.
    always_comb begin
        step = (state_q == ST_WARMUP) ||
               ((state_q == ST_RUN) && bus.ena && bus.rnd_req);
    end

    for (genvar i = 0; i < RANDNUM; i++) begin : g_lane
        xorshift64_lane
`ifdef MASK_RNG_HEALTH_EN
        #(
            .K_WIDTH (K_WIDTH)
        )
`endif
        u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (bus.seed_vld),
            .load_val (lane_seed(bus.seed, i)),
            .step     (step),
            .state    (lane_st[i]),
            .rep      (rep_vec[i])
        );
    end

    // FSM state and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a seed restarts warm-up from anywhere, else per-state rules.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.seed_vld) begin
            state_d = ST_WARMUP;
            cnt_d   = CW'(WARMUP);
        end else begin
            unique case (state_q)
                ST_WARMUP: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef MASK_RNG_HEALTH_EN
                    if (step && (|rep_vec)) begin
                        state_d = ST_FAIL;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Words are exposed only while RUN; otherwise the bus reads as zero.
    always_comb begin
        bus.rnd = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < RANDNUM; i++) begin
                bus.rnd[i*K_WIDTH +: K_WIDTH] = lane_st[i][K_WIDTH-1:0];
            end
        end
    end

    assign bus.rnd_vld = (state_q == ST_RUN);

`ifdef MASK_RNG_HEALTH_EN
    assign bus.health_fail = (state_q == ST_FAIL);
`else
    assign bus.health_fail = 1'b0;
`endif

    // Upper lane bits feed only the recurrence, not the output words.
    assign unused_bits = ^{lane_st, rep_vec};

endmodule
